// File: rtl/spio_spinnaker_link_sender.sv
// SpiNNaker link sender: 72-bit packet to NRZ 2-of-7 symbols with toggle ack; first symbol one cycle after accept in IDLE.
// Backpressure: PKT_RDY_OUT low while a packet occupies the buffer (freed as its EOP is driven); one symbol outstanding.
module spio_spinnaker_link_sender #(
    parameter int TMO_CYCLES = 256,
    parameter int BPP_W      = 5
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic [BPP_W-1:0] BPP_IN,
    output logic             ACK_ERR_OUT,
    output logic             TMO_ERR_OUT,
    input  logic [71:0]      PKT_DATA_IN,
    input  logic             PKT_VLD_IN,
    output logic             PKT_RDY_OUT,
    output logic [6:0]       SL_DATA_2OF7_OUT,
    input  logic             SL_ACK_IN
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;
    localparam int CNT_W = $clog2(TMO_CYCLES + 1);
    localparam logic [6:0] EOP_CODE = 7'b1100000;

    state_t           state, state_nxt;
    logic             ack_s1, ack_s2, ack_ref, ack_evt;
    logic             buf_vld;
    logic [71:0]      buf_dat;
    logic [4:0]       flit_idx, out_idx;
    logic             out_data;
    logic             rdy_en;
    logic [CNT_W-1:0] tmo_cnt;
    logic             send, ack_err, is_eop, frozen;
    logic [6:0]       nib_base, code;
    logic [3:0]       nibble;

    function automatic logic [6:0] enc_nibble(input logic [3:0] n);
        case (n)
            4'h0: enc_nibble = 7'b0010001;
            4'h1: enc_nibble = 7'b0010010;
            4'h2: enc_nibble = 7'b0010100;
            4'h3: enc_nibble = 7'b0011000;
            4'h4: enc_nibble = 7'b0100001;
            4'h5: enc_nibble = 7'b0100010;
            4'h6: enc_nibble = 7'b0100100;
            4'h7: enc_nibble = 7'b0101000;
            4'h8: enc_nibble = 7'b1000001;
            4'h9: enc_nibble = 7'b1000010;
            4'hA: enc_nibble = 7'b1000100;
            4'hB: enc_nibble = 7'b1001000;
            4'hC: enc_nibble = 7'b0000011;
            4'hD: enc_nibble = 7'b0000110;
            4'hE: enc_nibble = 7'b0001100;
            default: enc_nibble = 7'b0001001;
        endcase
    endfunction

    // Ack pins are asynchronous; the synchroniser free-runs so the reference can be loaded in reset.
    always_ff @(posedge CLK_IN) begin
        ack_s1 <= SL_ACK_IN;
        ack_s2 <= ack_s1;
    end

    assign ack_evt     = (ack_s2 != ack_ref);
    assign PKT_RDY_OUT = RESET_IN & rdy_en & ~buf_vld;

    // Symbol selection: header and key nibbles, optional payload, then EOP.
    always_comb begin
        is_eop   = (flit_idx == (buf_dat[1] ? 5'd18 : 5'd10));
        nib_base = is_eop ? 7'd0 : {flit_idx, 2'b00};
        nibble   = buf_dat[nib_base +: 4];
        code     = is_eop ? EOP_CODE : enc_nibble(nibble);
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) state <= WAIT_ACK;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (send) state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_evt && !send) state_nxt = IDLE;
            default:  state_nxt = WAIT_ACK;
        endcase
    end

    always_comb begin
        send    = 1'b0;
        ack_err = 1'b0;
        case (state)
            IDLE: begin
                ack_err = ack_evt;
                send    = buf_vld;
            end
            WAIT_ACK: send = ack_evt && buf_vld;
            default: ;
        endcase
    end

    // The outstanding data flit at the back-pressure point is exempt from the ack timeout.
    assign frozen = out_data && (BPP_W'(out_idx) == BPP_IN);

    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            SL_DATA_2OF7_OUT <= 7'd0;
            buf_vld          <= 1'b0;
            buf_dat          <= 72'd0;
            flit_idx         <= 5'd0;
            out_idx          <= 5'd0;
            out_data         <= 1'b0;
            rdy_en           <= 1'b0;
            tmo_cnt          <= '0;
            TMO_ERR_OUT      <= 1'b0;
            ACK_ERR_OUT      <= 1'b0;
            ack_ref          <= ack_s2;
        end else begin
            rdy_en      <= 1'b1;
            ACK_ERR_OUT <= ack_err;
            TMO_ERR_OUT <= 1'b0;
            if (ack_evt) ack_ref <= ack_s2;

            if (PKT_VLD_IN && PKT_RDY_OUT) begin
                buf_vld <= 1'b1;
                buf_dat <= PKT_DATA_IN;
            end

            if (send) begin
                SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ code;
                out_data         <= ~is_eop;
                out_idx          <= flit_idx;
                if (is_eop) begin
                    buf_vld  <= 1'b0;
                    flit_idx <= 5'd0;
                end else begin
                    flit_idx <= flit_idx + 5'd1;
                end
            end

            if (send || state != WAIT_ACK || (ack_evt && !send)) begin
                tmo_cnt <= '0;
            end else if (!frozen && tmo_cnt != CNT_W'(TMO_CYCLES)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                if (tmo_cnt == CNT_W'(TMO_CYCLES - 1)) TMO_ERR_OUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spio_spinnaker_link_sender.sv
// Directed bench for the SpiNNaker link sender: symbol codes, ack-paced timing, timeout and ack-error pulses.
module tb_spio_spinnaker_link_sender;

    localparam int TMO = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  bpp = 5'd31;
    logic        ack_err, tmo_err;
    logic [71:0] pkt_dat = '0;
    logic        pkt_vld = 1'b0;
    logic        pkt_rdy;
    logic [6:0]  sl_dat;
    logic        sl_ack = 1'b0;

    int total = 0;
    int bad = 0;
    int ack_err_hi = 0;
    int tmo_hi = 0;
    int sym_cnt = 0;
    bit acc_done = 1'b0;
    logic [6:0] prev_out = 7'd0;
    logic [6:0] obs_codes [19];

    spio_spinnaker_link_sender #(.TMO_CYCLES(TMO), .BPP_W(5)) dut (
        .CLK_IN(clk),
        .RESET_IN(rst_n),
        .BPP_IN(bpp),
        .ACK_ERR_OUT(ack_err),
        .TMO_ERR_OUT(tmo_err),
        .PKT_DATA_IN(pkt_dat),
        .PKT_VLD_IN(pkt_vld),
        .PKT_RDY_OUT(pkt_rdy),
        .SL_DATA_2OF7_OUT(sl_dat),
        .SL_ACK_IN(sl_ack)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_err) ack_err_hi++;
        if (tmo_err) tmo_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16] = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                               7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                               7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                               7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001};
        return t[n];
    endfunction

    function automatic logic [6:0] exp_code(input logic [71:0] d, input int i);
        int nd;
        nd = d[1] ? 18 : 10;
        if (i >= nd) return 7'b1100000;
        return enc(d[4*i +: 4]);
    endfunction

    task automatic send_pkt(input logic [71:0] d);
        int n = 0;
        while (!pkt_rdy && n < 400) begin
            tick();
            n++;
        end
        if (!pkt_rdy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            pkt_dat = d;
            pkt_vld = 1'b1;
            tick();
            pkt_vld = 1'b0;
            acc_done = 1'b1;
        end
    endtask

    task automatic wait_sym(input int exp_lat, input logic [6:0] exp, input int idx, input string tag);
        int n = 0;
        bit changed = 1'b0;
        while (!changed && n < 12) begin
            tick();
            n++;
            if (sl_dat != prev_out) changed = 1'b1;
        end
        if (!changed) begin
            chk($sformatf("%s_sym%0d_timeout", tag, idx), 0, 1);
        end else begin
            chk($sformatf("%s_sym%0d", tag, idx), sl_dat ^ prev_out, exp);
            if (exp_lat != 0) chk($sformatf("%s_sym%0d_lat", tag, idx), n, exp_lat);
            obs_codes[idx] = sl_dat ^ prev_out;
            prev_out = sl_dat;
            sym_cnt++;
        end
    endtask

    task automatic run_pkt(input logic [71:0] d, input int first_lat, input int hold,
                           input int stall_at, input int stall_len, input bit chk_acc,
                           input bit tail, input string tag);
        int ns;
        ns = d[1] ? 19 : 11;
        sym_cnt = 0;
        for (int i = 0; i < ns; i++) begin
            wait_sym((i == 0) ? first_lat : 3, exp_code(d, i), i, tag);
            repeat ((i == stall_at) ? stall_len : hold) tick();
            chk($sformatf("%s_hold%0d", tag, i), sl_dat, prev_out);
            if (chk_acc && i == ns - 1) chk({tag, "_next_accepted_before_eop_ack"}, acc_done, 1);
            sl_ack = ~sl_ack;
        end
        chk({tag, "_nsym"}, sym_cnt, ns);
        if (tail) begin
            repeat (6) tick();
            chk({tag, "_no_extra_sym"}, sl_dat, prev_out);
        end
    endtask

    logic [71:0] pkt_short, pkt_long, pkt_a, pkt_b;
    logic [6:0]  short_exp [11];
    int e0, t0;

    initial begin
        pkt_short = {32'h0, 32'h0000_0001, 8'h00};
        pkt_long  = {32'hA5A5_A5A5, 32'h0000_0001, 8'h82};
        pkt_a     = {32'h0, 32'h89AB_CDEF, 8'h01};
        pkt_b     = {32'hFEDC_BA90, 32'h1357_2468, 8'h02};
        short_exp = '{7'b0010001, 7'b0010001, 7'b0010010, 7'b0010001, 7'b0010001, 7'b0010001,
                      7'b0010001, 7'b0010001, 7'b0010001, 7'b0010001, 7'b1100000};

        // Reset
        repeat (3) tick();
        chk("rst_sl_data", sl_dat, 0);
        chk("rst_rdy", pkt_rdy, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_tmo_err", tmo_err, 0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_release", pkt_rdy, 1);

        // Packet buffered before the handshake must wait for it
        send_pkt(pkt_short);
        repeat (5) tick();
        chk("no_tx_before_hs", sl_dat, 0);
        sl_ack = 1'b1;
        run_pkt(pkt_short, 3, 1, -1, 0, 1'b0, 1'b1, "short");
        for (int i = 0; i < 11; i++) chk($sformatf("short_hand%0d", i), obs_codes[i], short_exp[i]);
        chk("hs_no_ack_err", ack_err_hi, 0);

        // Long packet sent from IDLE: first symbol one cycle after accept
        send_pkt(pkt_long);
        run_pkt(pkt_long, 1, 1, -1, 0, 1'b0, 1'b1, "long");
        chk("long_pay_nib0", obs_codes[10], 7'b0100010);
        chk("long_pay_nib1", obs_codes[11], 7'b1000100);
        chk("long_eop", obs_codes[18], 7'b1100000);

        // Back-to-back: second packet loads while first EOP ack is pending
        send_pkt(pkt_a);
        acc_done = 1'b0;
        fork
            begin
                run_pkt(pkt_a, 1, 2, -1, 0, 1'b1, 1'b0, "b2b_a");
                run_pkt(pkt_b, 3, 2, -1, 0, 1'b0, 1'b1, "b2b_b");
            end
            send_pkt(pkt_b);
        join
        chk("b2b_no_ack_err", ack_err_hi, 0);

        // Stall on flit 3 with BPP=6: one timeout pulse
        bpp = 5'd6;
        t0 = tmo_hi;
        send_pkt(pkt_short);
        run_pkt(pkt_short, 1, 1, 3, TMO + 5, 1'b0, 1'b1, "stall3");
        chk("stall3_tmo_pulse", tmo_hi - t0, 1);

        // Stall on flit 6 with BPP=6: exempt
        t0 = tmo_hi;
        send_pkt(pkt_short);
        run_pkt(pkt_short, 1, 1, 6, TMO + 5, 1'b0, 1'b1, "stall6");
        chk("stall6_no_tmo", tmo_hi - t0, 0);
        bpp = 5'd31;

        // Spurious ack in IDLE
        e0 = ack_err_hi;
        sl_ack = ~sl_ack;
        repeat (6) tick();
        chk("spurious_ack_err", ack_err_hi - e0, 1);
        chk("spurious_no_sym", sl_dat, prev_out);

        // Reset mid-packet
        send_pkt(pkt_long);
        sym_cnt = 0;
        wait_sym(1, exp_code(pkt_long, 0), 0, "mid");
        tick();
        sl_ack = ~sl_ack;
        wait_sym(3, exp_code(pkt_long, 1), 1, "mid");
        rst_n = 1'b0;
        tick();
        chk("mid_rst_sl_data", sl_dat, 0);
        chk("mid_rst_rdy", pkt_rdy, 0);
        tick();
        rst_n = 1'b1;
        prev_out = 7'd0;
        tick();
        chk("mid_rdy_after_release", pkt_rdy, 1);
        e0 = ack_err_hi;
        send_pkt(pkt_a);
        repeat (5) tick();
        chk("mid_no_tx_before_hs", sl_dat, 0);
        sl_ack = ~sl_ack;
        run_pkt(pkt_a, 3, 1, -1, 0, 1'b0, 1'b1, "after_rst");
        chk("after_rst_no_ack_err", ack_err_hi - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
